mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit that consumes the EX/MEM pipeline register's M-stage outputs.
- Runs a valid/ready request plus response handshake to a variable-latency data memory.
- Returns aligned, extended load data and drives Stall_M to the hazard unit, which holds the EX/MEM register (EN low) until the access completes.

Parameters:
- WIDTH_32, 32, data/address width (fixed 32; byte-lane logic assumes 4 lanes)
- WIDTH_BE, 4, byte-enable width (WIDTH_32/8)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- MemtoReg_M  in  1  load in M stage
- MemWrite_M  in  1  store in M stage
- ByteControl_M  in  2  00 word, 01 half signed, 10 byte signed, 11 byte unsigned
- ALU_result_M  in  32  effective byte address
- WriteData_M  in  32  store data (low bits significant)
- Flush_M  in  1  kill current M-stage access
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = store
- mem_req_addr  out  32  word address, {ALU_result_M[31:2],2'b00}
- mem_req_wdata  out  32  lane-replicated store data
- mem_req_be  out  4  byte enables, little-endian
- mem_rsp_valid  in  1  load response valid (one cycle per accepted load)
- mem_rsp_rdata  in  32  load response word
- ReadData_M  out  32  aligned/extended load result, registered
- Stall_M  out  1  hold pipeline; combinational

Behaviour:
- Reset: synchronous; while rst_n=0, state=IDLE, ReadData_M=0, and every output is forced 0.
- access = MemtoReg_M | MemWrite_M. If both are set, the store takes priority (illegal encoding; must not hang).
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE:
  - With access and !Flush_M: mem_req_valid=1 combinationally.
  - ready=1: store -> DONE; load -> WAIT.
  - ready=0: -> REQ.
- REQ: valid held high, fields stable (pipeline frozen).
  - ready=1: store -> DONE; load -> WAIT.
- WAIT: on mem_rsp_valid, latch the extended lane into ReadData_M, then -> DONE.
  - mem_rsp_valid in the same cycle as acceptance is illegal; responses arrive no earlier than the cycle after acceptance.
- DONE: Stall_M=0 for exactly one cycle so the EX/MEM register advances, then -> IDLE. No request is issued in DONE.
- Stall_M = access & (state != DONE). This gives:
  - Store, ready at cycle 0: one stall cycle.
  - Load, ready at cycle 0 and response at cycle 1: two stall cycles.
- Store lanes:
  - Word: be=1111, wdata=WriteData_M.
  - Half: be=0011 if addr[1]=0, else 1100; wdata={2{WriteData_M[15:0]}}.
  - Byte: be=0001<<addr[1:0]; wdata={4{WriteData_M[7:0]}}.
- Load lanes:
  - Half selects rdata[16*addr[1] +: 16] and sign-extends.
  - Byte selects rdata[8*addr[1:0] +: 8], sign- or zero-extended per ByteControl_M.
  - Loads drive be=1111.
- ReadData_M holds its value until the next load response.
- Flush_M handling:
  - In IDLE/REQ (not yet accepted): valid drops, -> IDLE, no memory side effect.
  - In WAIT: -> DRAIN.
  - In DRAIN: discard the response and return to IDLE. Stall_M=access while in DRAIN, so no new request is issued before the response.
  - In DONE: ignored.
- Misalignment without the macro: the low address bits beyond the lane selection are ignored. A word access forces addr[1:0]=0; a half access ignores addr[0].

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined:
  - Adds output MisalignExc_M (1 bit).
  - In IDLE, a word access with addr[1:0]!=0, or a half access with addr[0]=1, issues no request.
  - MisalignExc_M pulses high for that cycle, Stall_M=0, state stays IDLE.
  - ReadData_M is unchanged.
- When undefined: the port is absent and the forced-alignment behaviour above applies.

Decomposition:
- Shared package mips_mem_pkg holds:
  - ByteControl encodings (BC_WORD, BC_HALF, BC_BYTE, BC_BYTEU).
  - lsu_state_t enum.
  - WIDTH_32/WIDTH_BE constants.
- One combinational sub-module, mem_lane_align: store be/wdata generation plus load lane select/extend, for independent unit testing.

Test Plan:
- Word store, addr=0x0000_0104, data=0xDEADBEEF, ready=1 -> one cycle valid/we=1, be=1111, addr=0x104; Stall_M high 1 cycle.
- lb, addr=0x0000_0203, rsp rdata=0x80_12_34_56 one cycle after accept -> ReadData_M=0xFFFFFF80; lbu same -> 0x00000080; Stall_M high 2 cycles.
- sh, addr=0x0000_0012, data=0x0000_ABCD, ready low 3 cycles -> valid held 4 cycles, be=1100, wdata=0xABCDABCD, fields stable; Stall_M high 4 cycles.
- lh accepted, Flush_M in WAIT, response 2 cycles later with a new load pending -> response discarded, ReadData_M unchanged, new request only after the response.
- rst_n low in WAIT -> next edge IDLE, all outputs 0; a late mem_rsp_valid is ignored.
- MISALIGN_TRAP_EN: lw addr=0x0000_0101 -> MisalignExc_M=1 one cycle, mem_req_valid=0, Stall_M=0.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
// Contents: data/byte-enable widths, ByteControl encodings, the LSU state
// enum and a misalignment predicate used by the optional trap logic.
package mips_mem_pkg;

    localparam int WIDTH_32 = 32;
    localparam int WIDTH_BE = WIDTH_32 / 8;

    localparam logic [1:0] BC_WORD  = 2'b00;
    localparam logic [1:0] BC_HALF  = 2'b01;
    localparam logic [1:0] BC_BYTE  = 2'b10;
    localparam logic [1:0] BC_BYTEU = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } lsu_state_t;

    // Word access needs addr[1:0]==0, half access needs addr[0]==0.
    function automatic logic is_misaligned(input logic [1:0] bc, input logic [1:0] a);
        return ((bc == BC_WORD) && (a != 2'b00)) || ((bc == BC_HALF) && a[0]);
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
// Handshake: a request transfers on a cycle where mem_req_valid and
// mem_req_ready are both high; valid and all request fields stay stable
// until that cycle. Each accepted load returns exactly one mem_rsp_valid
// pulse carrying mem_rsp_rdata, no earlier than the cycle after acceptance.
interface mem_stage_lsu_if;
    import mips_mem_pkg::*;

    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_req_we;
    logic [WIDTH_32-1:0] mem_req_addr;
    logic [WIDTH_32-1:0] mem_req_wdata;
    logic [WIDTH_BE-1:0] mem_req_be;
    logic                mem_rsp_valid;
    logic [WIDTH_32-1:0] mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

endinterface

// File: rtl/mem_stage_lsu_lane_align.sv
// Combinational byte-lane logic for the LSU.
// Ports:
//   byte_ctrl_i   ByteControl encoding (word/half/byte/byte unsigned)
//   addr_lo_i     low two bits of the byte address
//   is_store_i    1 = store (lane-specific enables), 0 = load (all lanes)
//   store_data_i  store data, low bits significant
//   load_word_i   raw memory response word
//   be_o          byte enables, little-endian
//   wdata_o       lane-replicated store data
//   load_data_o   selected and extended load result
// Address bits below the access size are ignored here, which gives the
// forced-alignment behaviour when misalignment trapping is not built in.
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]          byte_ctrl_i,
    input  logic [1:0]          addr_lo_i,
    input  logic                is_store_i,
    input  logic [WIDTH_32-1:0] store_data_i,
    input  logic [WIDTH_32-1:0] load_word_i,
    output logic [WIDTH_BE-1:0] be_o,
    output logic [WIDTH_32-1:0] wdata_o,
    output logic [WIDTH_32-1:0] load_data_o
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    assign half_sel = load_word_i[16*addr_lo_i[1] +: 16];
    assign byte_sel = load_word_i[8*addr_lo_i +: 8];

    always_comb begin
        be_o        = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = load_word_i;
        case (byte_ctrl_i)
            BC_WORD: begin
                be_o        = 4'b1111;
                wdata_o     = store_data_i;
                load_data_o = load_word_i;
            end
            BC_HALF: begin
                if (is_store_i) be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o     = {2{store_data_i[15:0]}};
                load_data_o = {{16{half_sel[15]}}, half_sel};
            end
            BC_BYTE: begin
                if (is_store_i) be_o = 4'b0001 << addr_lo_i;
                wdata_o     = {4{store_data_i[7:0]}};
                load_data_o = {{24{byte_sel[7]}}, byte_sel};
            end
            default: begin
                if (is_store_i) be_o = 4'b0001 << addr_lo_i;
                wdata_o     = {4{store_data_i[7:0]}};
                load_data_o = {24'd0, byte_sel};
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues M-stage loads/stores to a
// variable-latency data memory and stalls the pipeline until done.
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   MemtoReg_M          load in M stage
//   MemWrite_M          store in M stage (wins if both are set)
//   ByteControl_M       access size / signedness
//   ALU_result_M        effective byte address
//   WriteData_M         store data
//   Flush_M             kill the current M-stage access
//   mem                 data-memory bus (master side)
//   ReadData_M          registered, aligned and extended load result
//   Stall_M             combinational hold request to the hazard unit
//   state_dbg_o         current FSM state
//   MisalignExc_M       misalignment trap pulse (only with MISALIGN_TRAP_EN)
// Optional feature macro: MISALIGN_TRAP_EN.
module mem_stage_lsu
    import mips_mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                MemtoReg_M,
    input  logic                MemWrite_M,
    input  logic [1:0]          ByteControl_M,
    input  logic [WIDTH_32-1:0] ALU_result_M,
    input  logic [WIDTH_32-1:0] WriteData_M,
    input  logic                Flush_M,
    mem_stage_lsu_if.master     mem,
    output logic [WIDTH_32-1:0] ReadData_M,
    output logic                Stall_M,
    output lsu_state_t          state_dbg_o
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                MisalignExc_M
`endif
);

    lsu_state_t          state_q;
    logic [WIDTH_32-1:0] rdata_q;
    logic                access;
    logic                is_store;
    logic                trap;
    logic                issue;
    logic [WIDTH_BE-1:0] lane_be;
    logic [WIDTH_32-1:0] lane_wdata;
    logic [WIDTH_32-1:0] lane_load;

    assign access   = MemtoReg_M | MemWrite_M;
    assign is_store = MemWrite_M;

`ifdef MISALIGN_TRAP_EN
    assign trap          = access & ~Flush_M & (state_q == ST_IDLE)
                         & is_misaligned(ByteControl_M, ALU_result_M[1:0]);
    assign MisalignExc_M = rst_n & trap;
`else
    assign trap = 1'b0;
`endif

    // A request is presented only before acceptance (IDLE or REQ).
    assign issue = access & ~Flush_M & ~trap
                 & ((state_q == ST_IDLE) | (state_q == ST_REQ));

    mem_lane_align u_lane_align (
        .byte_ctrl_i  (ByteControl_M),
        .addr_lo_i    (ALU_result_M[1:0]),
        .is_store_i   (is_store),
        .store_data_i (WriteData_M),
        .load_word_i  (mem.mem_rsp_rdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .load_data_o  (lane_load)
    );

    // Every output is held at zero while reset is asserted.
    assign mem.mem_req_valid = rst_n & issue;
    assign mem.mem_req_we    = rst_n & is_store;
    assign mem.mem_req_addr  = rst_n ? {ALU_result_M[31:2], 2'b00} : '0;
    assign mem.mem_req_wdata = rst_n ? lane_wdata : '0;
    assign mem.mem_req_be    = rst_n ? lane_be : '0;
    assign ReadData_M        = rst_n ? rdata_q : '0;
    assign Stall_M           = rst_n & access & (state_q != ST_DONE) & ~trap;
    assign state_dbg_o       = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        if (mem.mem_req_ready) state_q <= is_store ? ST_DONE : ST_WAIT;
                        else                   state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!access || Flush_M)     state_q <= ST_IDLE;
                    else if (mem.mem_req_ready) state_q <= is_store ? ST_DONE : ST_WAIT;
                end
                ST_WAIT: begin
                    // A flush coinciding with the response simply drops it.
                    if (mem.mem_rsp_valid) begin
                        if (Flush_M) begin
                            state_q <= ST_IDLE;
                        end else begin
                            rdata_q <= lane_load;
                            state_q <= ST_DONE;
                        end
                    end else if (Flush_M) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                ST_DRAIN: begin
                    if (mem.mem_rsp_valid) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: word/byte/half stores and loads,
// back-pressure, flush with drain, illegal load+store, reset mid-access
// and misalignment handling (trap or forced alignment per build).
module tb_mem_stage_lsu;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemtoReg_M, MemWrite_M, Flush_M;
    logic [1:0]  ByteControl_M;
    logic [31:0] ALU_result_M, WriteData_M;
    logic [31:0] ReadData_M;
    logic        Stall_M;
    lsu_state_t  state_dbg;
`ifdef MISALIGN_TRAP_EN
    logic        MisalignExc_M;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mem_stage_lsu_if mem_if ();

    mem_stage_lsu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .MemtoReg_M    (MemtoReg_M),
        .MemWrite_M    (MemWrite_M),
        .ByteControl_M (ByteControl_M),
        .ALU_result_M  (ALU_result_M),
        .WriteData_M   (WriteData_M),
        .Flush_M       (Flush_M),
        .mem           (mem_if.master),
        .ReadData_M    (ReadData_M),
        .Stall_M       (Stall_M),
        .state_dbg_o   (state_dbg)
`ifdef MISALIGN_TRAP_EN
        ,
        .MisalignExc_M (MisalignExc_M)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [1:0] bc,
                            input logic [31:0] addr, input logic [31:0] wd);
        MemtoReg_M    = ld;
        MemWrite_M    = st;
        ByteControl_M = bc;
        ALU_result_M  = addr;
        WriteData_M   = wd;
    endtask

    task automatic drive_mem(input logic rdy, input logic rv, input logic [31:0] rd);
        mem_if.mem_req_ready = rdy;
        mem_if.mem_rsp_valid = rv;
        mem_if.mem_rsp_rdata = rd;
    endtask

    task automatic clear_inputs();
        drive_op(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        Flush_M = 1'b0;
        drive_mem(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();

        // Reset with an access pending: outputs must stay zero.
        drive_op(1'b0, 1'b1, BC_WORD, 32'h104, 32'hDEADBEEF);
        drive_mem(1'b1, 1'b0, 32'h0);
        next_cycle();
        next_cycle();
        settle();
        check("rst_valid", {31'd0, mem_if.mem_req_valid}, 32'd0);
        check("rst_stall", {31'd0, Stall_M}, 32'd0);
        check("rst_we",    {31'd0, mem_if.mem_req_we}, 32'd0);
        check("rst_addr",  mem_if.mem_req_addr, 32'd0);
        check("rst_rdata", ReadData_M, 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));

        // Word store, ready immediately: one stall cycle.
        rst_n = 1'b1;
        settle();
        check("sw_valid", {31'd0, mem_if.mem_req_valid}, 32'd1);
        check("sw_we",    {31'd0, mem_if.mem_req_we}, 32'd1);
        check("sw_be",    {28'd0, mem_if.mem_req_be}, 32'hF);
        check("sw_addr",  mem_if.mem_req_addr, 32'h104);
        check("sw_wdata", mem_if.mem_req_wdata, 32'hDEADBEEF);
        check("sw_stall", {31'd0, Stall_M}, 32'd1);
        next_cycle();
        check("sw_done_state", 32'(state_dbg), 32'(ST_DONE));
        check("sw_done_stall", {31'd0, Stall_M}, 32'd0);
        check("sw_done_valid", {31'd0, mem_if.mem_req_valid}, 32'd0);

        // lb 0x203, response next cycle.
        next_cycle();
        drive_op(1'b1, 1'b0, BC_BYTE, 32'h203, 32'h0);
        drive_mem(1'b1, 1'b0, 32'h0);
        settle();
        check("lb_valid", {31'd0, mem_if.mem_req_valid}, 32'd1);
        check("lb_we",    {31'd0, mem_if.mem_req_we}, 32'd0);
        check("lb_be",    {28'd0, mem_if.mem_req_be}, 32'hF);
        check("lb_addr",  mem_if.mem_req_addr, 32'h200);
        check("lb_stall0", {31'd0, Stall_M}, 32'd1);
        next_cycle();
        drive_mem(1'b0, 1'b1, 32'h80123456);
        settle();
        check("lb_wait_valid", {31'd0, mem_if.mem_req_valid}, 32'd0);
        check("lb_stall1", {31'd0, Stall_M}, 32'd1);
        next_cycle();
        drive_mem(1'b0, 1'b0, 32'h0);
        settle();
        check("lb_stall2", {31'd0, Stall_M}, 32'd0);
        check("lb_data", ReadData_M, 32'hFFFFFF80);

        // lbu same address and data.
        next_cycle();
        drive_op(1'b1, 1'b0, BC_BYTEU, 32'h203, 32'h0);
        drive_mem(1'b1, 1'b0, 32'h0);
        next_cycle();
        drive_mem(1'b0, 1'b1, 32'h80123456);
        next_cycle();
        drive_mem(1'b0, 1'b0, 32'h0);
        settle();
        check("lbu_stall", {31'd0, Stall_M}, 32'd0);
        check("lbu_data", ReadData_M, 32'h00000080);

        // sh 0x12 with ready low for three cycles.
        next_cycle();
        drive_op(1'b0, 1'b1, BC_HALF, 32'h12, 32'h0000ABCD);
        drive_mem(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_if.mem_req_ready = 1'b1;
            settle();
            check($sformatf("sh_valid%0d", i), {31'd0, mem_if.mem_req_valid}, 32'd1);
            check($sformatf("sh_be%0d", i),    {28'd0, mem_if.mem_req_be}, 32'hC);
            check($sformatf("sh_wdata%0d", i), mem_if.mem_req_wdata, 32'hABCDABCD);
            check($sformatf("sh_addr%0d", i),  mem_if.mem_req_addr, 32'h10);
            check($sformatf("sh_stall%0d", i), {31'd0, Stall_M}, 32'd1);
            next_cycle();
        end
        check("sh_done_stall", {31'd0, Stall_M}, 32'd0);

        // sb 0x1: single-lane enable, replicated byte.
        next_cycle();
        drive_op(1'b0, 1'b1, BC_BYTE, 32'h1, 32'h1234565A);
        drive_mem(1'b1, 1'b0, 32'h0);
        settle();
        check("sb_be",    {28'd0, mem_if.mem_req_be}, 32'h2);
        check("sb_wdata", mem_if.mem_req_wdata, 32'h5A5A5A5A);
        next_cycle();
        check("sb_done", 32'(state_dbg), 32'(ST_DONE));

        // Load and store both set: store wins and completes.
        next_cycle();
        drive_op(1'b1, 1'b1, BC_WORD, 32'h300, 32'h55AA55AA);
        drive_mem(1'b1, 1'b0, 32'h0);
        settle();
        check("both_we", {31'd0, mem_if.mem_req_we}, 32'd1);
        next_cycle();
        check("both_done", 32'(state_dbg), 32'(ST_DONE));
        check("both_stall", {31'd0, Stall_M}, 32'd0);

        // lh 0x6: upper half, sign-extended.
        next_cycle();
        drive_op(1'b1, 1'b0, BC_HALF, 32'h6, 32'h0);
        drive_mem(1'b1, 1'b0, 32'h0);
        settle();
        check("lh_addr", mem_if.mem_req_addr, 32'h4);
        next_cycle();
        drive_mem(1'b0, 1'b1, 32'h80011234);
        next_cycle();
        drive_mem(1'b0, 1'b0, 32'h0);
        settle();
        check("lh_data", ReadData_M, 32'hFFFF8001);

        // lh accepted, flushed in WAIT, response two cycles later.
        next_cycle();
        drive_op(1'b1, 1'b0, BC_HALF, 32'h22, 32'h0);
        drive_mem(1'b1, 1'b0, 32'h0);
        next_cycle();
        Flush_M = 1'b1;
        drive_mem(1'b0, 1'b0, 32'h0);
        next_cycle();
        Flush_M = 1'b0;
        drive_op(1'b1, 1'b0, BC_WORD, 32'h40, 32'h0);
        drive_mem(1'b1, 1'b0, 32'h0);
        settle();
        check("fl_drain_state", 32'(state_dbg), 32'(ST_DRAIN));
        check("fl_drain_valid", {31'd0, mem_if.mem_req_valid}, 32'd0);
        check("fl_drain_stall", {31'd0, Stall_M}, 32'd1);
        next_cycle();
        drive_mem(1'b1, 1'b1, 32'h12345678);
        settle();
        check("fl_rsp_valid", {31'd0, mem_if.mem_req_valid}, 32'd0);
        next_cycle();
        drive_mem(1'b1, 1'b0, 32'h0);
        settle();
        check("fl_rdata_kept", ReadData_M, 32'hFFFF8001);
        check("fl_new_valid", {31'd0, mem_if.mem_req_valid}, 32'd1);
        check("fl_new_addr", mem_if.mem_req_addr, 32'h40);
        next_cycle();
        drive_mem(1'b0, 1'b1, 32'hCAFEF00D);
        next_cycle();
        drive_mem(1'b0, 1'b0, 32'h0);
        settle();
        check("fl_new_data", ReadData_M, 32'hCAFEF00D);
        check("fl_new_stall", {31'd0, Stall_M}, 32'd0);

        // Misaligned word load at 0x101.
        next_cycle();
        drive_op(1'b1, 1'b0, BC_WORD, 32'h101, 32'h0);
        drive_mem(1'b1, 1'b0, 32'h0);
        settle();
`ifdef MISALIGN_TRAP_EN
        check("mis_exc",   {31'd0, MisalignExc_M}, 32'd1);
        check("mis_valid", {31'd0, mem_if.mem_req_valid}, 32'd0);
        check("mis_stall", {31'd0, Stall_M}, 32'd0);
        next_cycle();
        drive_op(1'b0, 1'b0, BC_WORD, 32'h0, 32'h0);
        settle();
        check("mis_state", 32'(state_dbg), 32'(ST_IDLE));
        check("mis_exc_off", {31'd0, MisalignExc_M}, 32'd0);
        check("mis_rdata", ReadData_M, 32'hCAFEF00D);
`else
        check("al_valid", {31'd0, mem_if.mem_req_valid}, 32'd1);
        check("al_addr",  mem_if.mem_req_addr, 32'h100);
        next_cycle();
        drive_mem(1'b0, 1'b1, 32'h11223344);
        next_cycle();
        drive_mem(1'b0, 1'b0, 32'h0);
        settle();
        check("al_data", ReadData_M, 32'h11223344);
`endif

        // Reset while waiting for a load response; late response ignored.
        next_cycle();
        drive_op(1'b1, 1'b0, BC_HALF, 32'h2, 32'h0);
        drive_mem(1'b1, 1'b0, 32'h0);
        next_cycle();
        rst_n = 1'b0;
        drive_mem(1'b0, 1'b0, 32'h0);
        settle();
        check("rw_state_wait", 32'(state_dbg), 32'(ST_WAIT));
        check("rw_stall", {31'd0, Stall_M}, 32'd0);
        check("rw_rdata", ReadData_M, 32'd0);
        check("rw_be",    {28'd0, mem_if.mem_req_be}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        drive_op(1'b0, 1'b0, BC_WORD, 32'h0, 32'h0);
        drive_mem(1'b0, 1'b1, 32'hFFFF0000);
        settle();
        check("rw_state_idle", 32'(state_dbg), 32'(ST_IDLE));
        next_cycle();
        drive_mem(1'b0, 1'b0, 32'h0);
        settle();
        check("rw_late_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rw_late_rdata", ReadData_M, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
